// File: rtl/i2s_adc_rx_if.sv
// Signal bundle between the external I2S ADC pins and the receiver front end.
// The master side drives the serial pins; the slave side is the deserializer.
interface i2s_adc_rx_if #(
    parameter int DATA_W = 24
) ();
    logic              sck_i;
    logic              ws_i;
    logic              sd_i;
    logic [DATA_W-1:0] signal;
    logic              signal_en;
    logic              frame_err;

    modport master (
        output sck_i, ws_i, sd_i,
        input  signal, signal_en, frame_err
    );

    modport slave (
        input  sck_i, ws_i, sd_i,
        output signal, signal_en, frame_err
    );
endinterface

// File: rtl/i2s_adc_rx.sv
// I2S receiver: oversamples the ADC bit clock in the system clock domain and
// deserializes one channel into a DATA_W-bit word with a one-cycle strobe.
module i2s_adc_rx #(
    parameter int DATA_W  = 24,
    parameter int SLOT_W  = 32,
    parameter int CHANNEL = 0
) (
    input  logic         clk,
    input  logic         reset,
    i2s_adc_rx_if.slave  bus
);
    localparam int               CNT_W    = $clog2(SLOT_W + 3);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SLOT_W + 1);
    localparam logic             CH_WS    = 1'(CHANNEL);

    typedef enum logic [1:0] {IDLE, DELAY, SHIFT, SKIP} state_t;

    state_t            state_q, state_d;
    logic              sck_meta_q, sck_sync_q, sck_prev_q;
    logic              ws_meta_q, ws_sync_q, ws_prev_q, ws_prev_d;
    logic              sd_meta_q, sd_sync_q;
    logic [DATA_W-2:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] signal_q, signal_d;
    logic              signal_en_q, signal_en_d;
    logic              frame_err_q, frame_err_d;

    logic              sample_evt;
    logic              ws_edge;
    logic              enter_sel;
    logic [DATA_W-1:0] shift_in;
    logic [CNT_W-1:0]  cnt_inc;

    // A ws edge that lands outside IDLE is re-used as an IDLE entry on the
    // same sample event, so a slot boundary is never lost to error recovery.
    always_comb begin
        sample_evt  = sck_sync_q & ~sck_prev_q;
        ws_edge     = sample_evt & (ws_sync_q != ws_prev_q);
        enter_sel   = (ws_sync_q == CH_WS);
        shift_in    = {shift_q, sd_sync_q};
        cnt_inc     = cnt_q + CNT_ONE;

        state_d     = state_q;
        shift_d     = shift_q;
        cnt_d       = cnt_q;
        signal_d    = signal_q;
        signal_en_d = 1'b0;
        frame_err_d = 1'b0;
        ws_prev_d   = sample_evt ? ws_sync_q : ws_prev_q;

        if (sample_evt) begin
            case (state_q)
                IDLE: begin
                    if (ws_edge && enter_sel) state_d = DELAY;
                end
                DELAY: begin
                    shift_d = shift_in[DATA_W-2:0];
                    cnt_d   = CNT_ONE;
                    state_d = SHIFT;
                end
                SHIFT: begin
                    if (ws_edge) begin
                        frame_err_d = 1'b1;
                        state_d     = enter_sel ? DELAY : IDLE;
                    end else begin
                        shift_d = shift_in[DATA_W-2:0];
                        cnt_d   = cnt_inc;
                        if (cnt_inc == CNT_DATA) begin
                            signal_d    = shift_in;
                            signal_en_d = 1'b1;
                            state_d     = SKIP;
                        end
                    end
                end
                SKIP: begin
                    // Padding bits are only counted; a lost ws edge trips the limit.
                    if (ws_edge) begin
                        state_d = enter_sel ? DELAY : IDLE;
                    end else if (cnt_q >= CNT_MAX) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sck_meta_q  <= 1'b0;
            sck_sync_q  <= 1'b0;
            sck_prev_q  <= 1'b0;
            ws_meta_q   <= 1'b0;
            ws_sync_q   <= 1'b0;
            ws_prev_q   <= 1'b0;
            sd_meta_q   <= 1'b0;
            sd_sync_q   <= 1'b0;
            shift_q     <= '0;
            cnt_q       <= '0;
            state_q     <= IDLE;
            signal_q    <= '0;
            signal_en_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sck_meta_q  <= bus.sck_i;
            sck_sync_q  <= sck_meta_q;
            sck_prev_q  <= sck_sync_q;
            ws_meta_q   <= bus.ws_i;
            ws_sync_q   <= ws_meta_q;
            ws_prev_q   <= ws_prev_d;
            sd_meta_q   <= bus.sd_i;
            sd_sync_q   <= sd_meta_q;
            shift_q     <= shift_d;
            cnt_q       <= cnt_d;
            state_q     <= state_d;
            signal_q    <= signal_d;
            signal_en_q <= signal_en_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bus.signal    = signal_q;
    assign bus.signal_en = signal_en_q;
    assign bus.frame_err = frame_err_q;
endmodule
